// File: rtl/memoire_map_ws.sv
// memoire_map_ws: memory subsystem for the 6502 core.
// One CPU bus decoded into ROM, RAM and a single output register (PORT_OUT).
// Every access runs through IDLE -> (WAIT) -> ACCESS and ends with a one-cycle
// READY pulse. WAIT_STATES adds extra cycles per access.
// Ports:
//   CLK, RST_N        clock (rising edge) / asynchronous active-low reset
//   READ_ENABLE       read request, sampled in IDLE
//   WRITE_ENABLE      write request, sampled in IDLE, wins over READ_ENABLE
//   ADRESSE_CPU       access address
//   DATA_to_MEMORY_IN write data
//   DATA_MICRO_OUT    registered read data, holds the last read value
//   READY             one-cycle pulse when the access completes
//   BUSY              high whenever the FSM is not in IDLE
//   PORT_OUT          memory-mapped output register at IO_ADDR
//   ERR               sticky flag: write to ROM or to an unmapped address
// The ROM image comes from ROM_INIT (word i at bits [i*DATA_W +: DATA_W]),
// so the ROM is a pure constant and needs no load step.
module memoire_map_ws #(
  parameter int unsigned                 ADDR_W      = 16,
  parameter int unsigned                 DATA_W      = 8,
  parameter logic [ADDR_W-1:0]           ROM_BASE    = 16'h0000,
  parameter int unsigned                 ROM_DEPTH   = 32,
  parameter logic [ROM_DEPTH*DATA_W-1:0] ROM_INIT    = '0,
  parameter logic [ADDR_W-1:0]           RAM_BASE    = 16'h0020,
  parameter int unsigned                 RAM_DEPTH   = 32,
  parameter logic [ADDR_W-1:0]           IO_ADDR     = 16'h00FF,
  parameter int unsigned                 WAIT_STATES = 0,
  parameter logic [DATA_W-1:0]           OPEN_BUS    = 8'h00
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              READ_ENABLE,
  input  logic              WRITE_ENABLE,
  input  logic [ADDR_W-1:0] ADRESSE_CPU,
  input  logic [DATA_W-1:0] DATA_to_MEMORY_IN,
  output logic [DATA_W-1:0] DATA_MICRO_OUT,
  output logic              READY,
  output logic              BUSY,
  output logic [DATA_W-1:0] PORT_OUT,
  output logic              ERR
);

  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [3:0]  WS_M1  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t              state, state_nxt;
  logic                op_wr;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [3:0]          wcnt;
  logic [DATA_W-1:0]   ram [RAM_DEPTH];

  logic [ADDR_W:0]     rom_diff, ram_diff;
  logic                hit_rom, hit_ram, hit_io;
  logic [DATA_W-1:0]   rom_word, ram_word, rd_data;
  logic [RAM_AW-1:0]   ram_idx;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (WRITE_ENABLE || READ_ENABLE)
                  state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (wcnt == 4'd0) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign BUSY = (state != S_IDLE);

  // Decode on the latched address. The extra top bit of each difference is
  // the borrow, so an address below a region base never matches an index
  // (no wrap between regions).
  always_comb begin
    rom_diff = {1'b0, addr_q} - {1'b0, ROM_BASE};
    ram_diff = {1'b0, addr_q} - {1'b0, RAM_BASE};
    hit_rom  = 1'b0;
    hit_ram  = 1'b0;
    rom_word = '0;
    ram_idx  = '0;
    for (int unsigned i = 0; i < ROM_DEPTH; i++) begin
      if (rom_diff == (ADDR_W+1)'(i)) begin
        hit_rom  = 1'b1;
        rom_word = ROM_INIT[i*DATA_W +: DATA_W];
      end
    end
    for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
      if (ram_diff == (ADDR_W+1)'(i)) begin
        hit_ram = 1'b1;
        ram_idx = RAM_AW'(i);
      end
    end
    hit_io   = (addr_q == IO_ADDR);
    ram_word = ram[ram_idx];
    // First match wins: ROM, then RAM, then the IO register
    if (hit_rom)      rd_data = rom_word;
    else if (hit_ram) rd_data = ram_word;
    else if (hit_io)  rd_data = PORT_OUT;
    else              rd_data = OPEN_BUS;
  end

  // Control and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= S_IDLE;
      op_wr          <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      wcnt           <= '0;
      DATA_MICRO_OUT <= '0;
      READY          <= 1'b0;
      PORT_OUT       <= '0;
      ERR            <= 1'b0;
    end else begin
      state <= state_nxt;
      READY <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (WRITE_ENABLE || READ_ENABLE) begin
            op_wr  <= WRITE_ENABLE;
            addr_q <= ADRESSE_CPU;
            data_q <= DATA_to_MEMORY_IN;
            wcnt   <= WS_M1;
          end
        end
        S_WAIT: begin
          if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
        end
        S_ACCESS: begin
          READY <= 1'b1;
          if (!op_wr) begin
            DATA_MICRO_OUT <= rd_data;
          end else if (hit_rom) begin
            ERR <= 1'b1;
          end else if (!hit_ram) begin
            if (hit_io) PORT_OUT <= data_q;
            else        ERR      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM array: not cleared by reset. Reset forces IDLE asynchronously, so an
  // aborted access can never reach the write below.
  always_ff @(posedge CLK) begin
    if (state == S_ACCESS && op_wr && !hit_rom && hit_ram)
      ram[ram_idx] <= data_q;
  end

endmodule

// File: tb/tb_memoire_map_ws.sv
module tb_memoire_map_ws;

  logic        CLK;
  logic        RST_N;
  logic        re0, we0, re3, we3;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout0, port0, dout3, port3;
  logic        rdy0, busy0, err0, rdy3, busy3, err3;

  int checks = 0;
  int errors = 0;
  int lat, bcnt;

  // ROM image: word 3 = E9, word 31 (last) = A5, all others 00
  localparam logic [255:0] ROM_IMG = {8'hA5, 216'h0, 8'hE9, 24'h0};

  memoire_map_ws #(.ROM_INIT(ROM_IMG), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .READ_ENABLE(re0), .WRITE_ENABLE(we0),
    .ADRESSE_CPU(addr), .DATA_to_MEMORY_IN(din), .DATA_MICRO_OUT(dout0),
    .READY(rdy0), .BUSY(busy0), .PORT_OUT(port0), .ERR(err0));

  memoire_map_ws #(.ROM_INIT(ROM_IMG), .WAIT_STATES(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .READ_ENABLE(re3), .WRITE_ENABLE(we3),
    .ADRESSE_CPU(addr), .DATA_to_MEMORY_IN(din), .DATA_MICRO_OUT(dout3),
    .READY(rdy3), .BUSY(busy3), .PORT_OUT(port3), .ERR(err3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access: request is sampled at the edge after setup, then the bus is
  // scrambled so late address/data changes would be visible. Returns edges
  // from the sampling edge to READY, and the number of cycles BUSY was high.
  task automatic acc(input bit d3, input bit w, input bit r,
                     input logic [15:0] a, input logic [7:0] d,
                     output int l, output int b);
    @(posedge CLK); #1;
    if (d3) begin we3 = w; re3 = r; end
    else    begin we0 = w; re0 = r; end
    addr = a; din = d;
    @(posedge CLK); #1;
    we0 = 1'b0; re0 = 1'b0; we3 = 1'b0; re3 = 1'b0;
    addr = ~a; din = ~d;
    l = 0; b = 0;
    while (l < 40) begin
      if (d3 ? busy3 : busy0) b++;
      @(posedge CLK); #1;
      l++;
      if (d3 ? rdy3 : rdy0) break;
    end
  endtask

  initial begin
    RST_N = 1'b1;
    re0 = 1'b0; we0 = 1'b0; re3 = 1'b0; we3 = 1'b0;
    addr = '0; din = '0;
    #2 RST_N = 1'b0;
    #2;
    // Reset state
    chk("rst_dout0", dout0, 8'h00);
    chk("rst_ready0", rdy0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_port0", port0, 8'h00);
    chk("rst_err0", err0, 1'b0);
    chk("rst_busy3", busy3, 1'b0);
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;

    // ROM read, zero wait states
    acc(1'b0, 1'b0, 1'b1, 16'h0003, 8'h00, lat, bcnt);
    chk("rom3_lat", lat, 1);
    chk("rom3_busy_cycles", bcnt, 1);
    chk("rom3_data", dout0, 8'hE9);
    chk("rom3_busy_in_ready", busy0, 1'b0);
    @(posedge CLK); #1;
    chk("ready_one_cycle", rdy0, 1'b0);

    // RAM write then read-back
    acc(1'b0, 1'b1, 1'b0, 16'h0025, 8'h5A, lat, bcnt);
    chk("wr25_lat", lat, 1);
    chk("wr25_dout_held", dout0, 8'hE9);
    acc(1'b0, 1'b0, 1'b1, 16'h0025, 8'h00, lat, bcnt);
    chk("rd25_data", dout0, 8'h5A);
    chk("rd25_err", err0, 1'b0);

    // Region boundaries: last ROM word, last RAM word, first address past RAM
    acc(1'b0, 1'b0, 1'b1, 16'h001F, 8'h00, lat, bcnt);
    chk("rom_last", dout0, 8'hA5);
    acc(1'b0, 1'b1, 1'b0, 16'h003F, 8'h3C, lat, bcnt);
    acc(1'b0, 1'b0, 1'b1, 16'h003F, 8'h00, lat, bcnt);
    chk("ram_last", dout0, 8'h3C);
    acc(1'b0, 1'b0, 1'b1, 16'h0040, 8'h00, lat, bcnt);
    chk("past_ram_openbus", dout0, 8'h00);
    chk("past_ram_err", err0, 1'b0);

    // Illegal write to ROM, unmapped read
    acc(1'b0, 1'b0, 1'b1, 16'h0003, 8'h00, lat, bcnt);
    acc(1'b0, 1'b1, 1'b0, 16'h0003, 8'h77, lat, bcnt);
    chk("romwr_err", err0, 1'b1);
    chk("romwr_dout_held", dout0, 8'hE9);
    acc(1'b0, 1'b0, 1'b1, 16'h0003, 8'h00, lat, bcnt);
    chk("rom_unchanged", dout0, 8'hE9);
    acc(1'b0, 1'b0, 1'b1, 16'h0080, 8'h00, lat, bcnt);
    chk("unmapped_openbus", dout0, 8'h00);
    chk("unmapped_err_sticky", err0, 1'b1);

    // RE and WE together act as a write to the IO register
    acc(1'b0, 1'b0, 1'b1, 16'h0025, 8'h00, lat, bcnt);
    acc(1'b0, 1'b1, 1'b1, 16'h00FF, 8'hC3, lat, bcnt);
    chk("io_port", port0, 8'hC3);
    chk("io_dout_held", dout0, 8'h5A);
    acc(1'b0, 1'b0, 1'b1, 16'h00FF, 8'h00, lat, bcnt);
    chk("io_readback", dout0, 8'hC3);

    // Three wait states
    acc(1'b1, 1'b1, 1'b0, 16'h0020, 8'h9D, lat, bcnt);
    chk("ws3_wr_lat", lat, 4);
    acc(1'b1, 1'b0, 1'b1, 16'h0020, 8'h00, lat, bcnt);
    chk("ws3_rd_lat", lat, 4);
    chk("ws3_rd_busy_cycles", bcnt, 4);
    chk("ws3_rd_data", dout3, 8'h9D);

    // Reset in the middle of a waited write
    acc(1'b1, 1'b1, 1'b0, 16'h0021, 8'h66, lat, bcnt);
    @(posedge CLK); #1;
    we3 = 1'b1; addr = 16'h0021; din = 8'h11;
    @(posedge CLK); #1;
    we3 = 1'b0;
    @(posedge CLK); #1;
    chk("midwait_busy", busy3, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("abort_busy3", busy3, 1'b0);
    chk("abort_ready3", rdy3, 1'b0);
    chk("abort_dout3", dout3, 8'h00);
    chk("abort_err0", err0, 1'b0);
    chk("abort_port0", port0, 8'h00);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    acc(1'b1, 1'b0, 1'b1, 16'h0021, 8'h00, lat, bcnt);
    chk("abort_ram_kept", dout3, 8'h66);
    chk("abort_ram_lat", lat, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
